// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
//  Shared definitions for the alarm/chime sequencer of the digital clock:
//  - DIGIT_W   : width of one BCD time digit
//  - state_e   : sequencer states (IDLE, CHIME, RING, SNOOZE)
//  - BEE_*     : beeper request codes, bit0 = hourly chime, bit1 = alarm
//  - max3      : helper used to size the shared seconds counter
// -----------------------------------------------------------------------------
package timer_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHIME  = 2'd1,
    ST_RING   = 2'd2,
    ST_SNOOZE = 2'd3
  } state_e;

  localparam logic [1:0] BEE_OFF   = 2'b00;
  localparam logic [1:0] BEE_CHIME = 2'b01;
  localparam logic [1:0] BEE_ALARM = 2'b10;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// -----------------------------------------------------------------------------
// btn_sync_edge
//  Brings a raw asynchronous push button into the clk domain with a two-flop
//  synchronizer and turns each press into a single one-clk pulse on its
//  rising edge. Holding the button produces no further pulses.
// Ports
//  clk      in   system clock
//  rst_n    in   asynchronous active-low reset
//  btn_i    in   raw button, active high, asynchronous to clk
//  pulse_o  out  one-clk pulse per press
// -----------------------------------------------------------------------------
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // prev_q is the synchronized level one clk earlier, so this is high for
  // exactly the first clk after the synchronized level rises.
  assign pulse_o = sync_q & ~prev_q;

endmodule

// File: rtl/alarm_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_ctrl
//  Alarm/chime sequencer for the digital clock. Compares the running BCD time
//  against the alarm setting and the top of the hour, then drives the beeper
//  request lines. Handles ring timeout, snooze with a repeat limit, stop and
//  alarm enable.
// Parameters
//  RING_SEC    alarm ring duration in seconds before auto-stop
//  SNOOZE_SEC  snooze pause in seconds before re-ring
//  CHIME_SEC   hourly chime duration in seconds
//  MAX_SNOOZE  snoozes allowed per alarm event; the next snooze acts as stop
// Ports
//  clk, rst_n                  clock, asynchronous active-low reset
//  tick_1hz                    one-clk pulse per second (clk domain)
//  hour_t/hour_o/min_t/min_o/sec_t/sec_o   current time digits (BCD)
//  al_hour_t/al_hour_o/al_min_t/al_min_o   alarm time digits (BCD)
//  alarm_en                    alarm armed when high (level)
//  snooze_btn, stop_btn        raw push buttons, active high, asynchronous
//  bee_req                     {alarm, chime} request to the beeper
//  alarm_led                   high in RING or SNOOZE
//  snooze_cnt                  snoozes used in the current alarm event
// -----------------------------------------------------------------------------
module alarm_ctrl
  import timer_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int CHIME_SEC  = 2,
  parameter int MAX_SNOOZE = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_1hz,
  input  logic [DIGIT_W-1:0] hour_t,
  input  logic [DIGIT_W-1:0] hour_o,
  input  logic [DIGIT_W-1:0] min_t,
  input  logic [DIGIT_W-1:0] min_o,
  input  logic [DIGIT_W-1:0] sec_t,
  input  logic [DIGIT_W-1:0] sec_o,
  input  logic [DIGIT_W-1:0] al_hour_t,
  input  logic [DIGIT_W-1:0] al_hour_o,
  input  logic [DIGIT_W-1:0] al_min_t,
  input  logic [DIGIT_W-1:0] al_min_o,
  input  logic               alarm_en,
  input  logic               snooze_btn,
  input  logic               stop_btn,
  output logic [1:0]         bee_req,
  output logic               alarm_led,
  output logic [1:0]         snooze_cnt
);

  localparam int MAX_SEC = max3(RING_SEC, SNOOZE_SEC, CHIME_SEC);
  localparam int CNT_W   = $clog2(MAX_SEC + 1);

  localparam logic [CNT_W-1:0] RING_LD   = CNT_W'(RING_SEC);
  localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_SEC);
  localparam logic [CNT_W-1:0] CHIME_LD  = CNT_W'(CHIME_SEC);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [1:0]       SNZ_MAX   = 2'(MAX_SNOOZE);
  localparam logic [DIGIT_W-1:0] DIG_ZERO = '0;

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  logic snooze_p;
  logic stop_p;

  btn_sync_edge u_snooze_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (snooze_btn),
    .pulse_o (snooze_p)
  );

  btn_sync_edge u_stop_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (stop_btn),
    .pulse_o (stop_p)
  );

  // ---------------------------------------------------------------------------
  // Time compares
  // ---------------------------------------------------------------------------
  logic al_hit;
  logic top_hit;
  logic sec_zero;

  always_comb begin
    sec_zero = (sec_t == DIG_ZERO) && (sec_o == DIG_ZERO);
    al_hit   = alarm_en && sec_zero &&
               (hour_t == al_hour_t) && (hour_o == al_hour_o) &&
               (min_t  == al_min_t)  && (min_o  == al_min_o);
    top_hit  = sec_zero && (min_t == DIG_ZERO) && (min_o == DIG_ZERO);
  end

  // Registered compare and its one-clk-delayed copy. Both come out of reset
  // as "already matching": a time that still matches when reset is released
  // must not look like a fresh rising edge and re-trigger the alarm/chime.
  logic al_cmp_q;
  logic al_dly_q;
  logic top_cmp_q;
  logic top_dly_q;
  logic al_ev;
  logic top_ev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      al_cmp_q  <= 1'b1;
      al_dly_q  <= 1'b1;
      top_cmp_q <= 1'b1;
      top_dly_q <= 1'b1;
    end else begin
      al_cmp_q  <= al_hit;
      al_dly_q  <= al_cmp_q;
      top_cmp_q <= top_hit;
      top_dly_q <= top_cmp_q;
    end
  end

  assign al_ev  = al_cmp_q  & ~al_dly_q;
  assign top_ev = top_cmp_q & ~top_dly_q;

  // ---------------------------------------------------------------------------
  // Sequencer next-state
  // ---------------------------------------------------------------------------
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       snz_q;
  logic [1:0]       snz_d;
  logic [1:0]       bee_q;
  logic [1:0]       bee_d;
  logic             led_q;
  logic             led_d;
  logic             expire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snz_d   = snz_q;
    expire  = tick_1hz && (cnt_q == CNT_ONE);

    // Free-running countdown; any state change below overrides it with a
    // fresh load (or clears it on return to IDLE).
    if (tick_1hz && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_ONE;
    end

    case (state_q)
      ST_IDLE: begin
        if (al_ev) begin
          state_d = ST_RING;
          cnt_d   = RING_LD;
          snz_d   = 2'd0;
        end else if (top_ev) begin
          state_d = ST_CHIME;
          cnt_d   = CHIME_LD;
        end
      end

      ST_CHIME: begin
        if (al_ev) begin
          state_d = ST_RING;
          cnt_d   = RING_LD;
          snz_d   = 2'd0;
        end else if (expire) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      ST_RING: begin
        // Stop is tested first so a simultaneous stop+snooze is a stop.
        if (!alarm_en || stop_p) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (snooze_p) begin
          if (snz_q < SNZ_MAX) begin
            state_d = ST_SNOOZE;
            cnt_d   = SNOOZE_LD;
            snz_d   = snz_q + 2'd1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else if (expire) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      ST_SNOOZE: begin
        if (!alarm_en || stop_p) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (expire) begin
          state_d = ST_RING;
          cnt_d   = RING_LD;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register together
    // with the state and add no extra clk of latency.
    case (state_d)
      ST_RING:  bee_d = BEE_ALARM;
      ST_CHIME: bee_d = BEE_CHIME;
      default:  bee_d = BEE_OFF;
    endcase
    led_d = (state_d == ST_RING) || (state_d == ST_SNOOZE);
  end

  // ---------------------------------------------------------------------------
  // Sequencer registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      snz_q   <= 2'd0;
      bee_q   <= BEE_OFF;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      snz_q   <= snz_d;
      bee_q   <= bee_d;
      led_q   <= led_d;
    end
  end

  assign bee_req    = bee_q;
  assign alarm_led  = led_q;
  assign snooze_cnt = snz_q;

endmodule
